// File: rtl/pelican_pkg.sv
// Shared types, lamp encodings and small helpers for the pelican crossing controller.
package pelican_pkg;

  typedef enum logic [2:0] {
    StRed      = 3'd0,
    StRedAmber = 3'd1,
    StGreen    = 3'd2,
    StAmber    = 3'd3,
    StPedGreen = 3'd4,
    StPedClear = 3'd5
  } state_e;

  // Traffic lamps {RED,AMBER,GREEN}
  localparam logic [2:0] TL_R  = 3'b100;
  localparam logic [2:0] TL_RA = 3'b110;
  localparam logic [2:0] TL_G  = 3'b001;
  localparam logic [2:0] TL_A  = 3'b010;

  // Pedestrian lamps {RED,GREEN}
  localparam logic [1:0] PL_RED   = 2'b10;
  localparam logic [1:0] PL_GREEN = 2'b01;
  localparam logic [1:0] PL_DARK  = 2'b00;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [2:0] traffic_of(input state_e s);
    logic [2:0] tl;
    unique case (s)
      StRedAmber: tl = TL_RA;
      StGreen:    tl = TL_G;
      StAmber:    tl = TL_A;
      StPedClear: tl = TL_A;
      default:    tl = TL_R;
    endcase
    return tl;
  endfunction

  // Steady pedestrian aspect; the clearance blink is overlaid by the controller.
  function automatic logic [1:0] ped_of(input state_e s);
    logic [1:0] pl;
    unique case (s)
      StRed, StRedAmber, StGreen, StAmber: pl = PL_RED;
      StPedGreen, StPedClear:              pl = PL_GREEN;
      default:                             pl = PL_DARK;
    endcase
    return pl;
  endfunction

endpackage

// File: rtl/pelican_crossing_ctrl_if.sv
// Lamp/button bundle between the crossing controller and its environment.
interface pelican_crossing_ctrl_if #(
  parameter int unsigned N_REQ = 2
);
  logic [N_REQ-1:0] button;
  logic [2:0]       traffic_lights;
  logic [1:0]       pedestrian_lights;
  logic             req_pending;
  logic [2:0]       state_dbg;

  modport master (
    output button,
    input  traffic_lights,
    input  pedestrian_lights,
    input  req_pending,
    input  state_dbg
  );

  modport slave (
    input  button,
    output traffic_lights,
    output pedestrian_lights,
    output req_pending,
    output state_dbg
  );
endinterface

// File: rtl/pelican_crossing_ctrl_req_sync_edge.sv
// Two-flop synchroniser for one asynchronous button followed by a rising-edge pulse.
module req_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);
  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/pelican_crossing_ctrl.sv
// Pelican crossing controller: phase FSM, phase timer, request latch and lamp decode.
// Define PELICAN_PED_CLEAR_EN to add the flashing pedestrian clearance phase.
module pelican_crossing_ctrl
  import pelican_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 1000,
  parameter int unsigned T_RED_S       = 30,
  parameter int unsigned T_RA_S        = 3,
  parameter int unsigned T_GREEN_S     = 30,
  parameter int unsigned T_MIN_GREEN_S = 10,
  parameter int unsigned T_AMBER_S     = 3,
  parameter int unsigned T_PED_S       = 30,
  parameter int unsigned T_CLEAR_S     = 5,
  parameter int unsigned N_REQ         = 2
) (
  input logic                   clk,
  input logic                   rst,
  pelican_crossing_ctrl_if.slave bus
);

  localparam int unsigned RedCyc      = T_RED_S * CLK_HZ;
  localparam int unsigned RaCyc       = T_RA_S * CLK_HZ;
  localparam int unsigned GreenCyc    = T_GREEN_S * CLK_HZ;
  localparam int unsigned MinGreenCyc = T_MIN_GREEN_S * CLK_HZ;
  localparam int unsigned AmberCyc    = T_AMBER_S * CLK_HZ;
  localparam int unsigned PedCyc      = T_PED_S * CLK_HZ;
`ifdef PELICAN_PED_CLEAR_EN
  localparam int unsigned ClearCyc    = T_CLEAR_S * CLK_HZ;
  localparam int unsigned MaxCyc      = max2(max2(max2(RedCyc, RaCyc), max2(GreenCyc, AmberCyc)),
                                             max2(PedCyc, ClearCyc));
`else
  localparam int unsigned MaxCyc      = max2(max2(max2(RedCyc, RaCyc), max2(GreenCyc, AmberCyc)),
                                             PedCyc);
`endif
  localparam int unsigned TW = width_of(MaxCyc);

  typedef logic [TW-1:0] tmr_t;

  localparam tmr_t RedLast      = tmr_t'(RedCyc - 1);
  localparam tmr_t RaLast       = tmr_t'(RaCyc - 1);
  localparam tmr_t GreenLast    = tmr_t'(GreenCyc - 1);
  localparam tmr_t MinGreenLast = tmr_t'(MinGreenCyc - 1);
  localparam tmr_t AmberLast    = tmr_t'(AmberCyc - 1);
  localparam tmr_t PedLast      = tmr_t'(PedCyc - 1);
`ifdef PELICAN_PED_CLEAR_EN
  localparam tmr_t ClearLast    = tmr_t'(ClearCyc - 1);

  localparam int unsigned HalfCyc = CLK_HZ / 2;
  localparam int unsigned BW      = width_of(HalfCyc);
  typedef logic [BW-1:0] blk_t;
  localparam blk_t HalfLast = blk_t'(HalfCyc - 1);
`endif

  // Parameter sanity, caught at elaboration.
  if (T_MIN_GREEN_S > T_GREEN_S) begin : g_err_min_green
    $error("T_MIN_GREEN_S must not exceed T_GREEN_S");
  end
  if (T_RED_S == 0 || T_RA_S == 0 || T_GREEN_S == 0 || T_MIN_GREEN_S == 0 ||
      T_AMBER_S == 0 || T_PED_S == 0 || T_CLEAR_S == 0) begin : g_err_zero_phase
    $error("every T_*_S phase length must be at least 1 second");
  end
  if (N_REQ < 1) begin : g_err_n_req
    $error("N_REQ must be at least 1");
  end
`ifdef PELICAN_PED_CLEAR_EN
  if (CLK_HZ < 2) begin : g_err_blink
    $error("CLK_HZ must be at least 2 for the clearance blink");
  end
`endif

  logic [N_REQ-1:0] rise;

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    req_sync_edge u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (bus.button[i]),
      .rise     (rise[i])
    );
  end

  state_e     state_q, state_d;
  tmr_t       timer_q;
  logic       latch_q, latch_d;
  logic [2:0] tl_q, tl_d;
  logic [1:0] pl_q, pl_d;
  logic       edge_any, req, accepting, entering_ped;

  assign edge_any  = |rise;
  assign req       = latch_q | edge_any;
  assign accepting = (state_q == StRed) || (state_q == StRedAmber) ||
                     (state_q == StGreen) || (state_q == StAmber);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRed: begin
        if (req)                     state_d = StPedGreen;
        else if (timer_q == RedLast) state_d = StRedAmber;
      end
      StRedAmber: begin
        if (timer_q == RaLast) state_d = StGreen;
      end
      StGreen: begin
        if ((req && timer_q >= MinGreenLast) || timer_q == GreenLast) state_d = StAmber;
      end
      StAmber: begin
        if (timer_q == AmberLast) state_d = req ? StPedGreen : StRed;
      end
      StPedGreen: begin
`ifdef PELICAN_PED_CLEAR_EN
        if (timer_q == PedLast) state_d = StPedClear;
`else
        if (timer_q == PedLast) state_d = StRedAmber;
`endif
      end
`ifdef PELICAN_PED_CLEAR_EN
      StPedClear: begin
        if (timer_q == ClearLast) state_d = StRedAmber;
      end
`endif
      default: state_d = StRed;
    endcase
  end

  // Serving a request clears the latch; edges outside the traffic phases are dropped.
  assign entering_ped = (state_d == StPedGreen) && (state_q != StPedGreen);

  always_comb begin
    latch_d = latch_q;
    if (entering_ped)                latch_d = 1'b0;
    else if (edge_any && accepting)  latch_d = 1'b1;
  end

`ifdef PELICAN_PED_CLEAR_EN
  logic blink_on_q, blink_on_d;
  blk_t blink_cnt_q, blink_cnt_d;

  always_comb begin
    blink_on_d  = 1'b1;
    blink_cnt_d = '0;
    if (state_d == StPedClear && state_q == StPedClear) begin
      if (blink_cnt_q == HalfLast) begin
        blink_on_d  = ~blink_on_q;
        blink_cnt_d = '0;
      end else begin
        blink_on_d  = blink_on_q;
        blink_cnt_d = blink_cnt_q + blk_t'(1);
      end
    end
  end

  always_comb begin
    tl_d = traffic_of(state_d);
    pl_d = ped_of(state_d);
    if (state_d == StPedClear) pl_d = blink_on_d ? PL_GREEN : PL_DARK;
  end
`else
  always_comb begin
    tl_d = traffic_of(state_d);
    pl_d = ped_of(state_d);
  end
`endif

  // Lamps are registered from the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRed;
      timer_q     <= '0;
      latch_q     <= 1'b0;
      tl_q        <= TL_R;
      pl_q        <= PL_RED;
`ifdef PELICAN_PED_CLEAR_EN
      blink_on_q  <= 1'b1;
      blink_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= (state_d != state_q) ? '0 : timer_q + tmr_t'(1);
      latch_q     <= latch_d;
      tl_q        <= tl_d;
      pl_q        <= pl_d;
`ifdef PELICAN_PED_CLEAR_EN
      blink_on_q  <= blink_on_d;
      blink_cnt_q <= blink_cnt_d;
`endif
    end
  end

  assign bus.traffic_lights    = tl_q;
  assign bus.pedestrian_lights = pl_q;
  assign bus.req_pending       = latch_q;
  assign bus.state_dbg         = state_q;

endmodule

// File: tb/tb_pelican_crossing_ctrl.sv
// Directed bench for pelican_crossing_ctrl with CLK_HZ=10 (phases 300/30/300/30/300 cycles).
module tb_pelican_crossing_ctrl;
  import pelican_pkg::*;

  localparam int unsigned NREQ = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic pend_seen;

  pelican_crossing_ctrl_if #(.N_REQ(NREQ)) bus ();

  pelican_crossing_ctrl #(
    .CLK_HZ        (10),
    .T_RED_S       (30),
    .T_RA_S        (3),
    .T_GREEN_S     (30),
    .T_MIN_GREEN_S (10),
    .T_AMBER_S     (3),
    .T_PED_S       (30),
    .T_CLEAR_S     (5),
    .N_REQ         (NREQ)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.button = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts cycles (from the current one) for which both lamp groups hold the given aspect.
  task automatic measure(input logic [2:0] tl, input logic [1:0] pl, output int len);
    len = 0;
    while (bus.traffic_lights === tl && bus.pedestrian_lights === pl && len < 1000) begin
      if (bus.req_pending === 1'b1) pend_seen = 1'b1;
      len++;
      @(negedge clk);
    end
  endtask

  // Called at the first cycle after PED_GREEN; ends at RED_AMBER cycle 0.
  task automatic after_ped(input string tag);
    int len;
`ifdef PELICAN_PED_CLEAR_EN
    for (int k = 0; k < 5; k++) begin
      measure(TL_A, PL_GREEN, len);
      checks++;
      if (len !== 5) begin
        errors++;
        $display("FAIL %s_clear_on%0d: got %0d cycles expected 5", tag, k, len);
      end
      measure(TL_A, PL_DARK, len);
      checks++;
      if (len !== 5) begin
        errors++;
        $display("FAIL %s_clear_off%0d: got %0d cycles expected 5", tag, k, len);
      end
    end
`endif
    checks++;
    if (bus.traffic_lights !== TL_RA || bus.pedestrian_lights !== PL_RED) begin
      errors++;
      $display("FAIL %s_post_ped: got tl=%b pl=%b expected tl=110 pl=10", tag,
               bus.traffic_lights, bus.pedestrian_lights);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.traffic_lights !== TL_R) begin
      errors++;
      $display("FAIL reset_tl: got %b expected 100", bus.traffic_lights);
    end
    checks++;
    if (bus.pedestrian_lights !== PL_RED) begin
      errors++;
      $display("FAIL reset_pl: got %b expected 10", bus.pedestrian_lights);
    end
    checks++;
    if (bus.req_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_pend: got %b expected 0", bus.req_pending);
    end
    checks++;
    if (bus.state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", bus.state_dbg);
    end
  endtask

  task automatic test_idle();
    int len;
    do_reset();
    pend_seen = 1'b0;
    measure(TL_R, PL_RED, len);
    checks++;
    if (len !== 300) begin errors++; $display("FAIL idle_red: got %0d expected 300", len); end
    measure(TL_RA, PL_RED, len);
    checks++;
    if (len !== 30) begin errors++; $display("FAIL idle_ra: got %0d expected 30", len); end
    measure(TL_G, PL_RED, len);
    checks++;
    if (len !== 300) begin errors++; $display("FAIL idle_green: got %0d expected 300", len); end
    measure(TL_A, PL_RED, len);
    checks++;
    if (len !== 30) begin errors++; $display("FAIL idle_amber: got %0d expected 30", len); end
    checks++;
    if (bus.traffic_lights !== TL_R || bus.state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL idle_wrap: got tl=%b st=%0d expected tl=100 st=0", bus.traffic_lights,
               bus.state_dbg);
    end
    checks++;
    if (pend_seen !== 1'b0) begin
      errors++;
      $display("FAIL idle_pend: got %b expected 0", pend_seen);
    end
  endtask

  task automatic test_press_green();
    int len;
    do_reset();
    measure(TL_R, PL_RED, len);
    measure(TL_RA, PL_RED, len);
    tick(20);
    bus.button[0] = 1'b1;
    tick(2);
    checks++;
    if (bus.req_pending !== 1'b0) begin
      errors++;
      $display("FAIL green_pend_early: got %b expected 0", bus.req_pending);
    end
    tick(1);
    checks++;
    if (bus.req_pending !== 1'b1) begin
      errors++;
      $display("FAIL green_pend_set: got %b expected 1", bus.req_pending);
    end
    bus.button[0] = 1'b0;
    measure(TL_G, PL_RED, len);
    checks++;
    if (len !== 77) begin errors++; $display("FAIL green_min_end: got %0d expected 77", len); end
    measure(TL_A, PL_RED, len);
    checks++;
    if (len !== 30) begin errors++; $display("FAIL green_amber: got %0d expected 30", len); end
    checks++;
    if (bus.traffic_lights !== TL_R || bus.pedestrian_lights !== PL_GREEN ||
        bus.req_pending !== 1'b0) begin
      errors++;
      $display("FAIL green_ped_entry: got tl=%b pl=%b pend=%b expected 100 01 0",
               bus.traffic_lights, bus.pedestrian_lights, bus.req_pending);
    end
    pend_seen = 1'b0;
    measure(TL_R, PL_GREEN, len);
    checks++;
    if (len !== 300 || pend_seen !== 1'b0) begin
      errors++;
      $display("FAIL green_ped_len: got %0d pend=%b expected 300 pend=0", len, pend_seen);
    end
    after_ped("green");
  endtask

  task automatic test_press_late_green();
    int len;
    do_reset();
    measure(TL_R, PL_RED, len);
    measure(TL_RA, PL_RED, len);
    tick(250);
    bus.button[1] = 1'b1;
    tick(1);
    bus.button[1] = 1'b0;
    measure(TL_G, PL_RED, len);
    checks++;
    if (len !== 2) begin errors++; $display("FAIL late_green_end: got %0d expected 2", len); end
    measure(TL_A, PL_RED, len);
    checks++;
    if (len !== 30) begin errors++; $display("FAIL late_amber: got %0d expected 30", len); end
    checks++;
    if (bus.traffic_lights !== TL_R || bus.pedestrian_lights !== PL_GREEN) begin
      errors++;
      $display("FAIL late_ped_entry: got tl=%b pl=%b expected 100 01", bus.traffic_lights,
               bus.pedestrian_lights);
    end
  endtask

  task automatic test_press_red();
    int len;
    do_reset();
    pend_seen = 1'b0;
    tick(150);
    bus.button[0] = 1'b1;
    tick(1);
    bus.button[0] = 1'b0;
    measure(TL_R, PL_RED, len);
    checks++;
    if (len !== 2) begin errors++; $display("FAIL red_to_ped: got %0d expected 2", len); end
    checks++;
    if (bus.state_dbg !== 3'd4 || bus.pedestrian_lights !== PL_GREEN) begin
      errors++;
      $display("FAIL red_ped_state: got st=%0d pl=%b expected st=4 pl=01", bus.state_dbg,
               bus.pedestrian_lights);
    end
    // An edge in the middle of PED_GREEN must be ignored.
    tick(100);
    bus.button[1] = 1'b1;
    tick(1);
    bus.button[1] = 1'b0;
    tick(5);
    measure(TL_R, PL_GREEN, len);
    checks++;
    if (len !== 194 || pend_seen !== 1'b0) begin
      errors++;
      $display("FAIL red_ped_len: got %0d pend=%b expected 194 pend=0", len, pend_seen);
    end
    after_ped("red");
    measure(TL_RA, PL_RED, len);
    measure(TL_G, PL_RED, len);
    checks++;
    if (len !== 300) begin errors++; $display("FAIL ped_edge_ignored: got %0d expected 300", len); end
  endtask

  task automatic test_boundaries();
    int len;
    do_reset();
    measure(TL_R, PL_RED, len);
    measure(TL_RA, PL_RED, len);
    measure(TL_G, PL_RED, len);
    // Edge lands in the last AMBER cycle: still served.
    tick(27);
    bus.button[0] = 1'b1;
    tick(1);
    bus.button[0] = 1'b0;
    measure(TL_A, PL_RED, len);
    checks++;
    if (len !== 2 || bus.pedestrian_lights !== PL_GREEN) begin
      errors++;
      $display("FAIL amber_last_served: got len=%0d pl=%b expected 2 01", len,
               bus.pedestrian_lights);
    end
    // Edge lands in the last PED_GREEN cycle: dropped.
    tick(297);
    bus.button[1] = 1'b1;
    tick(1);
    bus.button[1] = 1'b0;
    measure(TL_R, PL_GREEN, len);
    checks++;
    if (len !== 2) begin errors++; $display("FAIL ped_last_len: got %0d expected 2", len); end
    after_ped("ped_last");
    checks++;
    if (bus.req_pending !== 1'b0) begin
      errors++;
      $display("FAIL ped_last_dropped: got pend=%b expected 0", bus.req_pending);
    end
    measure(TL_RA, PL_RED, len);
    measure(TL_G, PL_RED, len);
    checks++;
    if (len !== 300) begin errors++; $display("FAIL ped_last_green: got %0d expected 300", len); end
  endtask

  task automatic test_back_to_back();
    int len;
    do_reset();
    tick(100);
    for (int p = 0; p < 3; p++) begin
      bus.button[0] = 1'b1;
      tick(1);
      bus.button[0] = 1'b0;
      tick(1);
    end
    // Now at PED_GREEN cycle 3: first pulse served at RED cycle 102.
    checks++;
    if (bus.pedestrian_lights !== PL_GREEN) begin
      errors++;
      $display("FAIL pulses_ped: got pl=%b expected 01", bus.pedestrian_lights);
    end
    measure(TL_R, PL_GREEN, len);
    checks++;
    if (len !== 297) begin errors++; $display("FAIL pulses_ped_len: got %0d expected 297", len); end
    after_ped("pulses");
    measure(TL_RA, PL_RED, len);
    checks++;
    if (bus.traffic_lights !== TL_G) begin
      errors++;
      $display("FAIL pulses_single: got tl=%b expected 001", bus.traffic_lights);
    end
    // Held button from GREEN cycle 0: one request only.
    bus.button[0] = 1'b1;
    measure(TL_G, PL_RED, len);
    checks++;
    if (len !== 100) begin errors++; $display("FAIL held_green: got %0d expected 100", len); end
    measure(TL_A, PL_RED, len);
    measure(TL_R, PL_GREEN, len);
    checks++;
    if (len !== 300) begin errors++; $display("FAIL held_ped: got %0d expected 300", len); end
    after_ped("held");
    measure(TL_RA, PL_RED, len);
    bus.button[0] = 1'b0;
    measure(TL_G, PL_RED, len);
    checks++;
    if (len !== 300) begin errors++; $display("FAIL held_single: got %0d expected 300", len); end
  endtask

  task automatic test_mid_reset();
    int len;
    do_reset();
    measure(TL_R, PL_RED, len);
    measure(TL_RA, PL_RED, len);
    tick(20);
    bus.button[1] = 1'b1;
    tick(5);
    bus.button[1] = 1'b0;
    tick(25);
    checks++;
    if (bus.req_pending !== 1'b1 || bus.traffic_lights !== TL_G) begin
      errors++;
      $display("FAIL midrst_pre: got pend=%b tl=%b expected 1 001", bus.req_pending,
               bus.traffic_lights);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (bus.traffic_lights !== TL_R || bus.pedestrian_lights !== PL_RED ||
        bus.req_pending !== 1'b0) begin
      errors++;
      $display("FAIL midrst_post: got tl=%b pl=%b pend=%b expected 100 10 0",
               bus.traffic_lights, bus.pedestrian_lights, bus.req_pending);
    end
    measure(TL_R, PL_RED, len);
    checks++;
    if (len !== 300) begin errors++; $display("FAIL midrst_red: got %0d expected 300", len); end
    measure(TL_RA, PL_RED, len);
    measure(TL_G, PL_RED, len);
    checks++;
    if (len !== 300) begin errors++; $display("FAIL midrst_green: got %0d expected 300", len); end
  endtask

  initial begin
    bus.button = '0;
    pend_seen  = 1'b0;
    test_reset();
    test_idle();
    test_press_green();
    test_press_late_green();
    test_press_red();
    test_boundaries();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
